// File: rtl/ddr_txn_pkg.sv
// Shared types and constants for the DDR transaction-ID bookkeeping blocks.
package ddr_txn_pkg;

    localparam int unsigned RID_W   = 2;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned NUM_RID = 4;

    typedef enum logic [1:0] {IDLE, SERVE, POP} rid_state_t;

    typedef logic [IDX_W-1:0] rid_idx_t;
    typedef logic [RID_W-1:0] rid_t;

endpackage

// File: rtl/rid_rr_picker.sv
// Round-robin search: first present RID strictly after start_rid_i, ascending mod NUM_RID.
// start_rid_i itself is only chosen if it is the sole present RID.
module rid_rr_picker
    import ddr_txn_pkg::*;
(
    input  logic [NUM_RID-1:0] rid_present_i,
    input  logic [RID_W-1:0]   start_rid_i,
    output logic [RID_W-1:0]   next_rid_o,
    output logic               found_o
);

    logic [RID_W-1:0] cand;

    // Walk the ring starting one past start_rid_i; first hit wins.
    always_comb begin
        next_rid_o = '0;
        found_o    = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_RID; k++) begin
            cand = start_rid_i + RID_W'(k);
            if (!found_o && rid_present_i[cand]) begin
                next_rid_o = cand;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rid_tracker.sv
// Transaction-ID bookkeeping in front of transaction_fifo: issues load/pop strobes,
// tracks each live RID's FIFO slot index and selects current_rid round-robin.
// Optional service watchdog enabled by defining RID_TIMEOUT_EN.
module rid_tracker
    import ddr_txn_pkg::RID_W, ddr_txn_pkg::IDX_W, ddr_txn_pkg::rid_idx_t,
           ddr_txn_pkg::rid_state_t, ddr_txn_pkg::IDLE, ddr_txn_pkg::SERVE, ddr_txn_pkg::POP;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned NUM_RID        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [RID_W-1:0] req_rid,
    output logic             req_ready,
    input  logic             svc_done,
    output logic             load,
    output logic             pop,
    output logic [3:0]       rid_present,
    output logic [11:0]      rid_indexes,
    output logic [RID_W-1:0] current_rid,
    output logic             cur_valid,
    output logic [RID_W-1:0] popped_rid,
    output logic [2:0]       count,
    output logic             timeout
);

    // Never hold more live RIDs than the FIFO has slots.
    localparam int unsigned Cap = (DEPTH < NUM_RID) ? DEPTH : NUM_RID;

    rid_state_t       state_q, state_d;
    logic [3:0]       rid_present_q, rid_present_d;
    rid_idx_t         idx_q [4];
    rid_idx_t         idx_d [4];
    logic [2:0]       count_q, count_d;
    logic [RID_W-1:0] current_rid_q, current_rid_d;
    logic [RID_W-1:0] popped_rid_q, popped_rid_d;
    logic             pop_q, pop_d;
    logic             timeout_q, timeout_d;

    rid_idx_t         pop_idx;
    logic [3:0]       pick_present;
    logic [RID_W-1:0] pick_start;
    logic [RID_W-1:0] pick_rid;
    logic             pick_found;
    logic             rotate;

    // Accept gating; suppressed during reset since the FIFO is cleared on the same edge.
    always_comb begin
        req_ready = ~rid_present_q[req_rid] & (state_q != POP) & (count_q < 3'(Cap)) & ~rst;
        load      = req_valid & req_ready;
    end

    // One picker serves both post-pop selection (popped RID masked) and watchdog rotation.
    always_comb begin
        pick_start   = current_rid_q;
        pick_present = rid_present_q;
        if (state_q == POP) begin
            pick_start   = popped_rid_q;
            pick_present = rid_present_q & ~(4'b0001 << popped_rid_q);
        end
    end

    rid_rr_picker u_picker (
        .rid_present_i (pick_present),
        .start_rid_i   (pick_start),
        .next_rid_o    (pick_rid),
        .found_o       (pick_found)
    );

`ifdef RID_TIMEOUT_EN
    localparam logic [7:0] WdogMax = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       unused_pick_found;

    assign unused_pick_found = pick_found;

    // Service watchdog: counts SERVE cycles without svc_done; saturates when nothing to rotate to.
    always_comb begin
        wdog_d = '0;
        rotate = 1'b0;
        if (state_q == SERVE && !svc_done) begin
            if (wdog_q != WdogMax) begin
                wdog_d = wdog_q + 8'd1;
            end else if (count_q > 3'd1) begin
                rotate = 1'b1;
            end else begin
                wdog_d = wdog_q;
            end
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_cfg;

    assign rotate     = 1'b0;
    assign unused_cfg = (^TIMEOUT_CYCLES) ^ pick_found;
`endif

    // Index bookkeeping and FSM next state; load and pop are mutually exclusive by construction.
    always_comb begin
        state_d       = state_q;
        rid_present_d = rid_present_q;
        count_d       = count_q;
        current_rid_d = current_rid_q;
        popped_rid_d  = popped_rid_q;
        pop_d         = 1'b0;
        timeout_d     = 1'b0;
        pop_idx       = idx_q[popped_rid_q];
        for (int r = 0; r < 4; r++) begin
            idx_d[r] = idx_q[r];
        end

        if (load) begin
            // New entry enters at slot 0, everything else shifts back one.
            for (int r = 0; r < 4; r++) begin
                if (rid_present_q[r]) begin
                    idx_d[r] = idx_q[r] + 3'd1;
                end
            end
            idx_d[req_rid]         = '0;
            rid_present_d[req_rid] = 1'b1;
            count_d                = count_q + 3'd1;
        end else if (pop_q) begin
            // Entries behind the removed slot close the gap.
            for (int r = 0; r < 4; r++) begin
                if (rid_present_q[r] && idx_q[r] > pop_idx) begin
                    idx_d[r] = idx_q[r] - 3'd1;
                end
            end
            idx_d[popped_rid_q]         = '0;
            rid_present_d[popped_rid_q] = 1'b0;
            count_d                     = count_q - 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d       = SERVE;
                    current_rid_d = req_rid;
                end
            end
            SERVE: begin
                if (svc_done) begin
                    state_d      = POP;
                    pop_d        = 1'b1;
                    popped_rid_d = current_rid_q;
                end else if (rotate) begin
                    current_rid_d = pick_rid;
                    timeout_d     = 1'b1;
                end
            end
            POP: begin
                if (count_q > 3'd1) begin
                    state_d       = SERVE;
                    current_rid_d = pick_rid;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rid_present_q <= '0;
            count_q       <= '0;
            current_rid_q <= '0;
            popped_rid_q  <= '0;
            pop_q         <= 1'b0;
            timeout_q     <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                idx_q[r] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rid_present_q <= rid_present_d;
            count_q       <= count_d;
            current_rid_q <= current_rid_d;
            popped_rid_q  <= popped_rid_d;
            pop_q         <= pop_d;
            timeout_q     <= timeout_d;
            for (int r = 0; r < 4; r++) begin
                idx_q[r] <= idx_d[r];
            end
        end
    end

    assign pop         = pop_q;
    assign rid_present = rid_present_q;
    assign rid_indexes = {idx_q[3], idx_q[2], idx_q[1], idx_q[0]};
    assign current_rid = current_rid_q;
    assign cur_valid   = (state_q == SERVE);
    assign popped_rid  = popped_rid_q;
    assign count       = count_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rid_tracker.sv
// Bench for rid_tracker: directed vector table, reset/timeout sequences and a randomized
// run checked against a queue-based model (queue position == FIFO slot index).
module tb_rid_tracker;

    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_rid;
    logic        req_ready;
    logic        svc_done;
    logic        load;
    logic        pop;
    logic [3:0]  rid_present;
    logic [11:0] rid_indexes;
    logic [1:0]  current_rid;
    logic        cur_valid;
    logic [1:0]  popped_rid;
    logic [2:0]  count;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    rid_tracker #(
        .DEPTH          (8),
        .NUM_RID        (4),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rid     (req_rid),
        .req_ready   (req_ready),
        .svc_done    (svc_done),
        .load        (load),
        .pop         (pop),
        .rid_present (rid_present),
        .rid_indexes (rid_indexes),
        .current_rid (current_rid),
        .cur_valid   (cur_valid),
        .popped_rid  (popped_rid),
        .count       (count),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: mq[0] is the newest entry, so a RID's position is its FIFO index.
    int mq[$];
    int m_phase;  // 0 idle, 1 serving, 2 popping
    int m_cur;
    int m_popped;
    bit m_pop;
    bit m_to;
    int m_wd;
    bit e_load;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input int r);
        foreach (mq[i]) if (mq[i] == r) return i;
        return -1;
    endfunction

    // Next live RID after 'start' going up mod 4, never returning 'excl'.
    function automatic int next_after(input int start, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (c != excl && pos_of(c) >= 0) return c;
        end
        return start;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0; m_cur = 0; m_popped = 0; m_pop = 0; m_to = 0; m_wd = 0;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_all();
        bit        exp_ready;
        bit [3:0]  ep;
        bit [11:0] ei;
        ep = '0;
        ei = '0;
        exp_ready = !rst && pos_of(int'(req_rid)) < 0 && m_phase != 2 && mq.size() < 4;
        e_load = req_valid && exp_ready;
        for (int r = 0; r < 4; r++) begin
            int p;
            p = pos_of(r);
            if (p >= 0) begin
                ep[r] = 1'b1;
                ei[r*3 +: 3] = 3'(p);
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("load", 32'(load), 32'(e_load));
        chk("rid_present", 32'(rid_present), 32'(ep));
        chk("rid_indexes", 32'(rid_indexes), 32'(ei));
        chk("count", 32'(count), 32'(mq.size()));
        chk("cur_valid", 32'(cur_valid), 32'(m_phase == 1));
        if (m_phase == 1) chk("current_rid", 32'(current_rid), 32'(m_cur));
        chk("pop", 32'(pop), 32'(m_pop));
        if (m_pop) chk("popped_rid", 32'(popped_rid), 32'(m_popped));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // Advance the model across one clock edge using the inputs held during the cycle.
    task automatic model_update();
        int n_phase, n_cur, n_popped, n_wd;
        bit n_pop, n_to;
        if (rst) begin
            model_reset();
            return;
        end
        n_phase = m_phase; n_cur = m_cur; n_popped = m_popped;
        n_pop = 0; n_to = 0; n_wd = 0;
        case (m_phase)
            0: if (e_load) begin n_phase = 1; n_cur = int'(req_rid); end
            1: begin
                if (svc_done) begin
                    n_phase = 2; n_pop = 1; n_popped = m_cur;
                end
`ifdef RID_TIMEOUT_EN
                else if (m_wd == TC - 1) begin
                    if (mq.size() > 1) begin
                        n_cur = next_after(m_cur, -1);
                        n_to = 1;
                    end else begin
                        n_wd = m_wd;
                    end
                end else begin
                    n_wd = m_wd + 1;
                end
`endif
            end
            default: begin
                if (mq.size() - 1 > 0) begin
                    n_phase = 1;
                    n_cur = next_after(m_popped, m_popped);
                end else begin
                    n_phase = 0;
                end
            end
        endcase
        if (e_load) mq.push_front(int'(req_rid));
        else if (m_pop) mq.delete(pos_of(m_popped));
        m_phase = n_phase; m_cur = n_cur; m_popped = n_popped;
        m_pop = n_pop; m_to = n_to; m_wd = n_wd;
    endtask

    // Drive inputs just after an active edge, then check combinational + registered outputs.
    task automatic drive(input bit v, input bit [1:0] r, input bit d, input bit rs);
        req_valid = v; req_rid = r; svc_done = d; rst = rs;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit        v;
        bit [1:0]  rid;
        bit        done;
        bit        e_load;
        bit        e_pop;
        bit        e_cv;
        bit [1:0]  e_cur;
        bit [3:0]  e_pres;
        bit [11:0] e_idx;
        bit [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Hand-derived expectations; e_pres/e_idx/e_cnt/e_cv/e_pop are after the edge.
        vecs[0] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 12'h000, 3'd1};
        vecs[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 12'h000, 3'd1};
        vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h000, 3'd0};
        vecs[3] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 12'h000, 3'd1};
        vecs[4] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0011, 12'h001, 3'd2};
        vecs[5] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1011, 12'h00A, 3'd3};
        vecs[6] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1011, 12'h00A, 3'd3};
        vecs[7] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1011, 12'h00A, 3'd3};
        vecs[8] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 12'h008, 3'd2};
        vecs[9] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1110, 12'h210, 3'd3};

        rst = 1'b1; req_valid = 1'b0; req_rid = '0; svc_done = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        drive(0, 0, 0, 1);
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].rid, vecs[i].done, 0);
            chk($sformatf("tbl%0d_load", i), 32'(load), 32'(vecs[i].e_load));
            tick();
            chk($sformatf("tbl%0d_pop", i), 32'(pop), 32'(vecs[i].e_pop));
            chk($sformatf("tbl%0d_cv", i), 32'(cur_valid), 32'(vecs[i].e_cv));
            if (vecs[i].e_cv) chk($sformatf("tbl%0d_cur", i), 32'(current_rid), 32'(vecs[i].e_cur));
            chk($sformatf("tbl%0d_pres", i), 32'(rid_present), 32'(vecs[i].e_pres));
            chk($sformatf("tbl%0d_idx", i), 32'(rid_indexes), 32'(vecs[i].e_idx));
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(vecs[i].e_cnt));
        end

        // Reset asserted mid-SERVE clears every output on the next edge
        drive(1, 0, 0, 1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_outs", {rid_indexes, rid_present, count, current_rid, popped_rid,
                         cur_valid, pop, timeout, req_ready, load}, 32'd0);

`ifdef RID_TIMEOUT_EN
        // Two live RIDs, no svc_done: rotation after TC serving cycles
        drive(1, 1, 0, 0); tick();
        drive(1, 2, 0, 0); tick();
        for (int i = 0; i < 14; i++) begin drive(0, 0, 0, 0); tick(); end
        chk("wd_early", 32'(timeout), 32'd0);
        drive(0, 0, 0, 0); tick();
        chk("wd_pulse", 32'(timeout), 32'd1);
        chk("wd_cur", 32'(current_rid), 32'd2);
        drive(0, 0, 0, 1); tick();
        // One live RID: saturates, never rotates
        drive(1, 1, 0, 0); tick();
        for (int i = 0; i < 24; i++) begin
            drive(0, 0, 0, 0); tick();
            chk("wd_single", 32'(timeout), 32'd0);
        end
        chk("wd_single_cur", 32'(current_rid), 32'd1);
        drive(0, 0, 0, 1); tick();
`endif

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
